// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pc_fetch_unit_pkg
//  Brief   : Shared constants, state encodings and helpers for the F-stage PC.
//  Revision: 1.0  initial release
// ============================================================================
package pc_fetch_unit_pkg;

    localparam int                 c_pc_w     = 32;
    localparam logic [c_pc_w-1:0]  c_reset_pc = 32'h0000_3000;
    localparam logic [c_pc_w-1:0]  c_pc_step  = 32'd4;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Instruction fetch is word-granular; low address bits are dropped on load.
    function automatic logic [c_pc_w-1:0] word_align(input logic [c_pc_w-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] lo);
        return |lo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_pending_buf.sv
`default_nettype none
// ============================================================================
//  Module  : pc_pending_buf
//  Brief   : One-deep redirect target buffer with valid flag (load/clear).
//  Revision: 1.0  initial release
// ============================================================================
module pc_pending_buf
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W = c_pc_w
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [PC_W-1:0] i_target,
    output logic            o_valid,
    output logic [PC_W-1:0] o_target
);

    logic            r_valid;
    logic [PC_W-1:0] r_target;

    // A load always overwrites: the newest captured redirect is the one kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (i_load) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end else if (i_clear) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : pc_fetch_unit
//  Brief   : F-stage program counter with D-stage redirects and stall buffering.
//  Revision: 1.0  initial release
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter int          PC_W     = c_pc_w
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            jr_valid,
    input  logic [PC_W-1:0] jr_target,
    output logic [PC_W-1:0] PC_F,
    output logic [PC_W-1:0] PC4_F,
    output logic            pending,
    output logic            adel_f,
    output logic            redirect_clash
);

    logic [0:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_adel;
    logic            r_clash;

    logic [0:0]      w_state_nxt;
    logic            w_req;
    logic [PC_W-1:0] w_req_tgt;
    logic [PC_W-1:0] w_load_tgt;
    logic            w_pc_load;
    logic            w_pc_step;
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_buf_load;
    logic            w_buf_clear;
    logic            w_buf_valid;
    logic [PC_W-1:0] w_buf_target;

    assign w_pc4 = r_pc + c_pc_step;

    pc_pending_buf #(
        .PC_W (PC_W)
    ) u_pending_buf (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_buf_load),
        .i_clear  (w_buf_clear),
        .i_target (w_req_tgt),
        .o_valid  (w_buf_valid),
        .o_target (w_buf_target)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_load   = 1'b0;
        w_pc_step   = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_clear = 1'b0;
        w_req       = redirect_valid | jr_valid;
        // Branch/jump outranks jr when both arrive together.
        w_req_tgt   = redirect_valid ? redirect_target : jr_target;
        w_load_tgt  = w_req_tgt;

        case (r_state)
            ST_RUN: begin
                if (!stall) begin
                    if (w_req) w_pc_load = 1'b1;
                    else       w_pc_step = 1'b1;
                end else if (w_req) begin
                    w_buf_load  = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stall) begin
                    w_buf_load = w_req;
                end else begin
                    // A live request is newer than anything buffered.
                    w_buf_clear = 1'b1;
                    w_state_nxt = ST_RUN;
                    if (w_req) begin
                        w_pc_load = 1'b1;
                    end else if (w_buf_valid) begin
                        w_pc_load  = 1'b1;
                        w_load_tgt = w_buf_target;
                    end else begin
                        w_pc_step = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (w_pc_load)      w_pc_nxt = word_align(w_load_tgt);
        else if (w_pc_step) w_pc_nxt = w_pc4;
        else                w_pc_nxt = r_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_adel  <= 1'b0;
            r_clash <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_adel  <= w_pc_load & is_misaligned(w_load_tgt[1:0]);
            r_clash <= redirect_valid & jr_valid;
        end
    end

    assign PC_F           = r_pc;
    assign PC4_F          = w_pc4;
    assign pending        = (r_state == ST_HOLD);
    assign adel_f         = r_adel;
    assign redirect_clash = r_clash;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pc_fetch_unit
//  Brief   : Scoreboard bench for pc_fetch_unit redirect/stall behaviour.
//  Revision: 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        jr_valid;
    logic [31:0] jr_target;
    logic [31:0] PC_F;
    logic [31:0] PC4_F;
    logic        pending;
    logic        adel_f;
    logic        redirect_clash;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        adel;
        logic        clash;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        st;
        logic        rv;
        logic [31:0] rt;
        logic        jv;
        logic [31:0] jt;
        exp_t        e;
    } row_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .jr_valid        (jr_valid),
        .jr_target       (jr_target),
        .PC_F            (PC_F),
        .PC4_F           (PC4_F),
        .pending         (pending),
        .adel_f          (adel_f),
        .redirect_clash  (redirect_clash)
    );

    function automatic row_t mk(input logic rst, input logic st,
                                input logic rv, input logic [31:0] rt,
                                input logic jv, input logic [31:0] jt,
                                input logic [31:0] epc, input logic ep,
                                input logic ea, input logic ec);
        row_t r;
        r.rst = rst; r.st = st; r.rv = rv; r.rt = rt; r.jv = jv; r.jt = jt;
        r.e.pc = epc; r.e.pend = ep; r.e.adel = ea; r.e.clash = ec;
        return r;
    endfunction

    function automatic logic [66:0] pack_exp(input exp_t e);
        logic [31:0] pc4;
        pc4 = e.pc + 32'd4;
        return {e.pc, pc4, e.pend, e.adel, e.clash};
    endfunction

    // Drive one cycle of stimulus, queue its expectation, sample 1 ns after the edge.
    task automatic drive(input row_t r);
        reset           = r.rst;
        stall           = r.st;
        redirect_valid  = r.rv;
        redirect_target = r.rt;
        jr_valid        = r.jv;
        jr_target       = r.jt;
        sb.push_back(r.e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        logic [66:0] obs, req;
        rows.push_back(mk(1, 0, 1, 32'h0000_5000, 0, 0, 32'h3000, 0, 0, 0));
        rows.push_back(mk(1, 1, 1, 32'h0000_5001, 1, 32'h6000, 32'h3000, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            e   = sb.pop_front();
            obs = {PC_F, PC4_F, pending, adel_f, redirect_clash};
            req = pack_exp(e);
            n_cmp++;
            if (obs !== req) begin
                n_bad++;
                $display("FAIL reset[%0d]: got pc/pc4/pend/adel/clash=%h, want %h", i, obs, req);
            end
        end
    endtask

    task automatic test_redirect();
        row_t rows[$];
        exp_t e;
        logic [66:0] obs, req;
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 32'h3100, 0, 0, 32'h3100, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3104, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            e   = sb.pop_front();
            obs = {PC_F, PC4_F, pending, adel_f, redirect_clash};
            req = pack_exp(e);
            n_cmp++;
            if (obs !== req) begin
                n_bad++;
                $display("FAIL redirect[%0d]: got pc/pc4/pend/adel/clash=%h, want %h", i, obs, req);
            end
        end
    endtask

    task automatic test_stall_buffer();
        row_t rows[$];
        exp_t e;
        logic [66:0] obs, req;
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 32'h3104, 0, 0, 0));
        rows.push_back(mk(0, 1, 1, 32'h3200, 0, 0, 32'h3104, 1, 0, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 32'h3104, 1, 0, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 32'h3104, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3200, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3204, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            e   = sb.pop_front();
            obs = {PC_F, PC4_F, pending, adel_f, redirect_clash};
            req = pack_exp(e);
            n_cmp++;
            if (obs !== req) begin
                n_bad++;
                $display("FAIL stall_buffer[%0d]: got pc/pc4/pend/adel/clash=%h, want %h", i, obs, req);
            end
        end
    endtask

    task automatic test_hold_priority();
        row_t rows[$];
        exp_t e;
        logic [66:0] obs, req;
        // live jr at release beats buffered target
        rows.push_back(mk(0, 1, 1, 32'h3300, 0, 0, 32'h3204, 1, 0, 0));
        rows.push_back(mk(0, 1, 1, 32'h3380, 0, 0, 32'h3204, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 1, 32'h3400, 32'h3400, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3404, 0, 0, 0));
        // newest capture during stall wins
        rows.push_back(mk(0, 1, 1, 32'h3500, 0, 0, 32'h3404, 1, 0, 0));
        rows.push_back(mk(0, 1, 0, 0, 1, 32'h3580, 32'h3404, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3580, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3584, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            e   = sb.pop_front();
            obs = {PC_F, PC4_F, pending, adel_f, redirect_clash};
            req = pack_exp(e);
            n_cmp++;
            if (obs !== req) begin
                n_bad++;
                $display("FAIL hold_priority[%0d]: got pc/pc4/pend/adel/clash=%h, want %h", i, obs, req);
            end
        end
    endtask

    task automatic test_clash_align_wrap();
        row_t rows[$];
        exp_t e;
        logic [66:0] obs, req;
        rows.push_back(mk(0, 0, 1, 32'h3500, 1, 32'h3600, 32'h3500, 0, 0, 1));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3504, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 1, 32'h3402, 32'h3400, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3404, 0, 0, 0));
        rows.push_back(mk(0, 1, 1, 32'h3601, 0, 0, 32'h3404, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3600, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3604, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            e   = sb.pop_front();
            obs = {PC_F, PC4_F, pending, adel_f, redirect_clash};
            req = pack_exp(e);
            n_cmp++;
            if (obs !== req) begin
                n_bad++;
                $display("FAIL clash_align_wrap[%0d]: got pc/pc4/pend/adel/clash=%h, want %h", i, obs, req);
            end
        end
    endtask

    task automatic test_reset_in_hold();
        row_t rows[$];
        exp_t e;
        logic [66:0] obs, req;
        rows.push_back(mk(0, 1, 1, 32'h3700, 0, 0, 32'h0000_0000, 1, 0, 0));
        rows.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i]);
            e   = sb.pop_front();
            obs = {PC_F, PC4_F, pending, adel_f, redirect_clash};
            req = pack_exp(e);
            n_cmp++;
            if (obs !== req) begin
                n_bad++;
                $display("FAIL reset_in_hold[%0d]: got pc/pc4/pend/adel/clash=%h, want %h", i, obs, req);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        jr_valid        = 1'b0;
        jr_target       = '0;
        test_reset();
        test_redirect();
        test_stall_buffer();
        test_hold_priority();
        test_clash_align_wrap();
        test_reset_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
